stagef_word_packer: RTL and testbench



---
 rtl/stagef_pkg.sv | 40 ++++
 rtl/stagef_fifo.sv | 58 +++++
 rtl/stagef_word_packer.sv | 107 ++++++++++
 tb/tb_stagef_word_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stagef_pkg.sv
// Shared types for the Stage-F to Stage-D word: field widths, the packed 260-bit word, JAL helpers.
// No logic; pure types and constants.
// Used by stagef_word_packer and its testbench.
package stagef_pkg;

  localparam int XLEN       = 64;
  localparam int DII_ID_W   = 23;
  localparam int EPOCH_W    = 2;
  localparam int PRIV_W     = 2;
  localparam int EXC_CODE_W = 6;
  localparam int INSTR_W    = 32;
  localparam int WORD_W     = 260;

  typedef logic [XLEN-1:0]     xlen_t;
  typedef logic [DII_ID_W-1:0] dii_id_t;

  localparam logic [6:0] OPC_JAL          = 7'b1101111;
  localparam xlen_t      DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // MSB first: fetch_addr lands in [259:196], pred_fetch_addr in [63:0].
  typedef struct packed {
    xlen_t                 fetch_addr;
    logic                  refresh_pcc;
    dii_id_t               instr_seq;
    logic [EPOCH_W-1:0]    epoch;
    logic [PRIV_W-1:0]     priv;
    logic                  is_i32_not_i16;
    logic                  exc;
    logic [EXC_CODE_W-1:0] exc_code;
    xlen_t                 tval;
    logic [INSTR_W-1:0]    instr;
    xlen_t                 pred_fetch_addr;
  } stagef_word_t;

  // Sign-extended J-type immediate of a JAL instruction.
  function automatic xlen_t jal_offset(input logic [INSTR_W-1:0] instr);
    return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/stagef_fifo.sv
// DEPTH-entry synchronous FIFO with flush and occupancy count.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes beyond DEPTH are dropped internally; caller gates pushes on count.
module stagef_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 260
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // A flush swallows any same-cycle push or pop.
  always_comb begin
    push    = push_vld && !flush && (count < DEPTH_C);
    pop_vld = (count != '0);
    pop     = pop_vld && pop_rdy && !flush;
    pop_dat = pop_vld ? mem[rd_ptr] : '0;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stagef_word_packer.sv
// Packs raw fetch slots into Stage-F-to-Stage-D words; owns pc/epoch/priv/instr_seq.
// Latency 1: out_valid rises the cycle after an accept. Optional JAL prediction: STAGEF_PACKER_JAL_PRED_EN.
// Backpressure: in_ready depends only on registered FIFO count, redirect and reset; never on out_ready.
module stagef_word_packer
  import stagef_pkg::*;
#(
  parameter int         DEPTH      = 2,
  parameter xlen_t      RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic                  in_exc,
  input  logic [EXC_CODE_W-1:0] in_exc_code,
  input  logic                  redirect_valid,
  input  xlen_t                 redirect_addr,
  input  logic [PRIV_W-1:0]     redirect_priv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output dii_id_t               seq_next
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  xlen_t              pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [PRIV_W-1:0]  priv_q;
  dii_id_t            seq_q;
  logic               refresh_q;

  stagef_word_t       word;
  logic               is_i32;
  xlen_t              pred_addr;
  logic               accept;
  logic               fifo_vld;
  logic [WORD_W-1:0]  fifo_dat;
  logic [CW-1:0]      fifo_count;

  assign in_ready  = !RST && !redirect_valid && (fifo_count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = !RST && fifo_vld;
  assign out_data  = RST ? '0 : fifo_dat;
  assign seq_next  = RST ? '0 : seq_q;

  // Build the packed word and next-pc prediction for the slot on the inputs.
  always_comb begin
    is_i32    = (in_instr[1:0] == 2'b11);
    pred_addr = pc_q + (is_i32 ? 64'd4 : 64'd2);
`ifdef STAGEF_PACKER_JAL_PRED_EN
    if (is_i32 && !in_exc && (in_instr[6:0] == OPC_JAL))
      pred_addr = pc_q + jal_offset(in_instr);
`endif
    word                 = '0;
    word.fetch_addr      = pc_q;
    word.refresh_pcc     = refresh_q;
    word.instr_seq       = seq_q;
    word.epoch           = epoch_q;
    word.priv            = priv_q;
    word.is_i32_not_i16  = is_i32;
    word.exc             = in_exc;
    word.exc_code        = in_exc ? in_exc_code : '0;
    word.tval            = in_exc ? pc_q : '0;
    word.instr           = in_exc ? '0 : (is_i32 ? in_instr : {16'h0, in_instr[15:0]});
    word.pred_fetch_addr = pred_addr;
  end

  // Fetch state: redirect takes priority; it never coincides with an accept since in_ready drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= RESET_PC;
      epoch_q   <= '0;
      priv_q    <= RESET_PRIV;
      seq_q     <= '0;
      refresh_q <= 1'b1;
    end else if (redirect_valid) begin
      pc_q      <= redirect_addr;
      priv_q    <= redirect_priv;
      epoch_q   <= epoch_q + EPOCH_W'(1);
      refresh_q <= 1'b1;
    end else if (accept) begin
      pc_q      <= pred_addr;
      seq_q     <= seq_q + DII_ID_W'(1);
      refresh_q <= 1'b0;
    end
  end

  stagef_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .flush    (redirect_valid),
    .push_vld (accept),
    .push_dat (word),
    .pop_vld  (fifo_vld),
    .pop_rdy  (out_ready),
    .pop_dat  (fifo_dat),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_stagef_word_packer.sv
// Directed bench for stagef_word_packer: vector table for packing, hand sequences for
// backpressure, redirect/flush, epoch wrap, seq wrap, pc wrap and reset mid-stream.
// Inputs driven and outputs sampled on the falling edge.
module tb_stagef_word_packer;
  import stagef_pkg::*;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = '0;
  logic          in_exc = 1'b0;
  logic [5:0]    in_exc_code = '0;
  logic          redirect_valid = 1'b0;
  xlen_t         redirect_addr = '0;
  logic [1:0]    redirect_priv = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [259:0]  out_data;
  dii_id_t       seq_next;

  int checks = 0;
  int errors = 0;

  localparam xlen_t B = 64'h8000_0000;
`ifdef STAGEF_PACKER_JAL_PRED_EN
  localparam xlen_t JT = 64'h8000_0018;  // jal +8 taken from 0x80000010
  localparam xlen_t JP = 64'h8000_0008;  // jal +8 taken from 0x80000000
`else
  localparam xlen_t JT = 64'h8000_0014;
  localparam xlen_t JP = 64'h8000_0004;
`endif
  localparam xlen_t P0 = JT + 64'd4;

  stagef_word_packer dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_exc         (in_exc),
    .in_exc_code    (in_exc_code),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .redirect_priv  (redirect_priv),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .seq_next       (seq_next)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stagef_word_t mk(input xlen_t fa, input logic rf, input dii_id_t sq,
                                      input logic [1:0] ep, input logic [1:0] pv, input logic i32,
                                      input logic ex, input logic [5:0] cd, input xlen_t tv,
                                      input logic [31:0] ins, input xlen_t pr);
    stagef_word_t w;
    w.fetch_addr = fa;  w.refresh_pcc = rf;  w.instr_seq = sq;  w.epoch = ep;
    w.priv = pv;  w.is_i32_not_i16 = i32;  w.exc = ex;  w.exc_code = cd;
    w.tval = tv;  w.instr = ins;  w.pred_fetch_addr = pr;
    return w;
  endfunction

  typedef struct {
    logic [31:0]  instr;
    logic         exc;
    logic [5:0]   code;
    stagef_word_t exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h0000_0013, 1'b0, 6'd0,  mk(B,         1, 0, 0, 3, 1, 0, 0,  0,         32'h13,        B + 64'h4)};
    tbl[1] = '{32'hABCD_4501, 1'b0, 6'd0,  mk(B + 64'h4, 0, 1, 0, 3, 0, 0, 0,  0,         32'h4501,      B + 64'h6)};
    tbl[2] = '{32'h0000_0013, 1'b0, 6'd0,  mk(B + 64'h6, 0, 2, 0, 3, 1, 0, 0,  0,         32'h13,        B + 64'hA)};
    tbl[3] = '{32'h0000_0013, 1'b1, 6'd1,  mk(B + 64'hA, 0, 3, 0, 3, 1, 1, 1,  B + 64'hA, 32'h0,         B + 64'hE)};
    tbl[4] = '{32'h0000_0001, 1'b0, 6'h3F, mk(B + 64'hE, 0, 4, 0, 3, 0, 0, 0,  0,         32'h1,         B + 64'h10)};
    tbl[5] = '{32'h0080_006F, 1'b0, 6'd0,  mk(B + 64'h10,0, 5, 0, 3, 1, 0, 0,  0,         32'h0080_006F, JT)};
    tbl[6] = '{32'h0080_006F, 1'b1, 6'd12, mk(JT,        0, 6, 0, 3, 1, 1, 12, JT,        32'h0,         JT + 64'h4)};

    // Reset state, with a request offered during reset.
    @(negedge CLK);
    @(negedge CLK);
    in_valid = 1'b1;
    check("rst_in_ready", 260'(in_ready), 260'(0));
    check("rst_out_valid", 260'(out_valid), 260'(0));
    check("rst_out_data", out_data, 260'(0));
    check("rst_seq_next", 260'(seq_next), 260'(0));
    in_valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", 260'(in_ready), 260'(1));
    check("post_rst_out_valid", 260'(out_valid), 260'(0));

    // Streaming vector table, one accept per cycle with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      in_exc = tbl[i].exc;
      in_exc_code = tbl[i].code;
      check($sformatf("vec%0d_in_ready", i), 260'(in_ready), 260'(1));
      @(negedge CLK);
      check($sformatf("vec%0d_out_valid", i), 260'(out_valid), 260'(1));
      check($sformatf("vec%0d_word", i), out_data, tbl[i].exp);
      check($sformatf("vec%0d_seq_next", i), 260'(seq_next), 260'(i + 1));
    end
    in_valid = 1'b0;
    in_exc = 1'b0;
    in_exc_code = '0;
    @(negedge CLK);
    check("drain_out_valid", 260'(out_valid), 260'(0));
    check("drain_out_data", out_data, 260'(0));

    // Backpressure: fill both entries, hold, then drain in order with a third word queued.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h13;
    @(negedge CLK);
    @(negedge CLK);
    check("full_in_ready", 260'(in_ready), 260'(0));
    check("full_head", out_data, mk(P0, 0, 7, 0, 3, 1, 0, 0, 0, 32'h13, P0 + 64'h4));
    @(negedge CLK);
    check("hold_in_ready", 260'(in_ready), 260'(0));
    check("hold_head_stable", out_data, mk(P0, 0, 7, 0, 3, 1, 0, 0, 0, 32'h13, P0 + 64'h4));
    out_ready = 1'b1;
    @(negedge CLK);
    check("drain1_in_ready", 260'(in_ready), 260'(1));
    check("drain1_word", out_data, mk(P0 + 64'h4, 0, 8, 0, 3, 1, 0, 0, 0, 32'h13, P0 + 64'h8));
    @(negedge CLK);
    in_valid = 1'b0;
    check("drain2_word", out_data, mk(P0 + 64'h8, 0, 9, 0, 3, 1, 0, 0, 0, 32'h13, P0 + 64'hC));
    @(negedge CLK);
    check("drain3_empty", 260'(out_valid), 260'(0));

    // Redirect with two words buffered and the consumer ready: flush wins, seq continues.
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    redirect_valid = 1'b1;
    redirect_addr = 64'h1000;
    redirect_priv = 2'd0;
    out_ready = 1'b1;
    check("redir_in_ready", 260'(in_ready), 260'(0));
    check("redir_pre_valid", 260'(out_valid), 260'(1));
    @(negedge CLK);
    redirect_valid = 1'b0;
    check("flush_out_valid", 260'(out_valid), 260'(0));
    check("flush_out_data", out_data, 260'(0));
    check("flush_seq_next", 260'(seq_next), 260'(12));
    @(negedge CLK);
    in_valid = 1'b0;
    check("redir_word", out_data, mk(64'h1000, 1, 12, 1, 0, 1, 0, 0, 0, 32'h13, 64'h1004));

    // Three more redirects wrap the epoch to 0; last target makes the pc wrap to 0.
    redirect_valid = 1'b1;
    redirect_addr = 64'h2000;
    redirect_priv = 2'd1;
    @(negedge CLK);
    redirect_addr = 64'h3000;
    redirect_priv = 2'd2;
    @(negedge CLK);
    redirect_addr = 64'hFFFF_FFFF_FFFF_FFFE;
    redirect_priv = 2'd1;
    @(negedge CLK);
    redirect_valid = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h4501;
    @(negedge CLK);
    in_valid = 1'b0;
    check("epoch_wrap_word", out_data,
          mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 13, 0, 1, 0, 0, 0, 0, 32'h4501, 64'h0));

    // Sequence number wraps from all-ones to zero.
    force dut.seq_q = 23'h7F_FFFF;
    #1;
    release dut.seq_q;
    check("seq_forced", 260'(seq_next), 260'(23'h7F_FFFF));
    in_valid = 1'b1;
    in_instr = 32'h13;
    @(negedge CLK);
    check("seq_max_word", out_data, mk(64'h0, 0, 23'h7F_FFFF, 0, 1, 1, 0, 0, 0, 32'h13, 64'h4));
    check("seq_wrap_next", 260'(seq_next), 260'(0));
    @(negedge CLK);
    in_valid = 1'b0;
    check("seq_zero_word", out_data, mk(64'h4, 0, 0, 0, 1, 1, 0, 0, 0, 32'h13, 64'h8));

    // Reset mid-stream discards the buffered word and all fetch state.
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    check("pre_rst_valid", 260'(out_valid), 260'(1));
    RST = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    check("mid_rst_valid", 260'(out_valid), 260'(0));
    check("mid_rst_in_ready", 260'(in_ready), 260'(0));
    check("mid_rst_seq_next", 260'(seq_next), 260'(0));
    RST = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("after_rst_valid", 260'(out_valid), 260'(0));

    // JAL at the reset pc: prediction depends on the optional feature.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0080_006F;
    @(negedge CLK);
    check("jal_word", out_data, mk(B, 1, 0, 0, 3, 1, 0, 0, 0, 32'h0080_006F, JP));
    in_instr = 32'h13;
    @(negedge CLK);
    in_valid = 1'b0;
    check("jal_next_word", out_data, mk(JP, 0, 1, 0, 3, 1, 0, 0, 0, 32'h13, JP + 64'h4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
